link_tx_sched: RTL and testbench
================================

Name: link_tx_sched

Overview:
- Sequences the shared link-layer TX packet sender, which emits TOKEN and HANDSHAKE packets.
- Arbitrates between two requesters:
  - the handshake responder, which issues ACK/NAK/STALL replies;
  - the host token scheduler, which issues IN/OUT/SETUP tokens.
- Issues one tx_valid start pulse per packet, waits for the sender to finish, then enforces an inter-packet gap.
- Handshakes have priority, with a burst limit so tokens are not starved.

Parameters:
- GAP_CYCLES, 4: idle cycles after a packet completes before the next grant. 0 means no gap.
- HS_BURST, 2: maximum consecutive handshake grants while tk_req is pending. Must be at least 1.
- TIMEOUT, 64: maximum cycles to wait for tx_ready to return high before aborting.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hs_req  in  1  handshake request; held until hs_ack
- hs_pid  in  4  handshake PID
- hs_ack  out  1  one-cycle accept pulse
- tk_req  in  1  token request; held until tk_ack
- tk_pid  in  4  token PID
- tk_addr  in  7  token device address
- tk_endp  in  4  token endpoint
- tk_ack  out  1  one-cycle accept pulse
- tx_pid  out  4  PID to sender
- tx_addr  out  7  address to sender
- tx_endp  out  4  endpoint to sender
- tx_valid  out  1  one-cycle start pulse to sender
- tx_ready  in  1  sender idle (low while a packet is in flight)
- busy  out  1  high in any state other than IDLE
- err_pid  out  1  one-cycle pulse on an illegal-PID rejection
- err_timeout  out  1  one-cycle pulse on a watchdog abort

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - hs_streak 0, gap counter 0, watchdog counter 0.
- Reset asserted mid-packet returns to IDLE on the next edge. No ack or tx_valid is emitted, and the in-flight request is not acknowledged.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Arbitrates only when tx_ready=1 and (hs_req or tk_req).
  - Winner selection:
    - hs_req only: handshake wins;
    - tk_req only: token wins;
    - both: handshake wins if hs_streak < HS_BURST, otherwise token wins.
  - On the grant edge:
    - latch the winner's fields into tx_pid/tx_addr/tx_endp;
    - a handshake grant forces tx_addr=0 and tx_endp=0;
    - next state ISSUE.
  - tx_ready=0 in IDLE: stall, no grant.
- PID legality:
  - handshake requires pid[1:0]=2'b10;
  - token requires pid[1:0]=2'b01.
  - An illegal winner is still acked in ISSUE, but tx_valid stays 0, err_pid=1, and the next state is GAP.
- hs_streak update:
  - handshake grant with tk_req=1: increment, saturating at HS_BURST;
  - handshake grant with tk_req=0: reset to 0;
  - token grant: reset to 0.
- ISSUE (exactly 1 cycle):
  - tx_valid=1, and the winner's ack=1 in the same cycle;
  - next state WAIT_DONE, with the watchdog cleared.
  - Requests are ignored; requesters drop req in the cycle after ack.
- Latency: request seen in IDLE at cycle N → tx_valid and ack at cycle N+1.
- WAIT_DONE:
  - The sender drops tx_ready from cycle N+2.
  - The state is left on the first cycle tx_ready=1, going to GAP, or to IDLE if GAP_CYCLES=0.
  - The watchdog increments each cycle. On reaching TIMEOUT with tx_ready still 0: err_timeout pulse, next state GAP.
- GAP:
  - Counts GAP_CYCLES cycles, then returns to IDLE.
  - Requests arriving during GAP wait; nothing is lost.
- tx_pid/tx_addr/tx_endp hold their values until the next grant.

Test Plan:
1. hs_req=1, hs_pid=4'h2, tx_ready=1 in IDLE at cycle 0:
   - tx_valid=1, hs_ack=1, tx_pid=4'h2, tx_addr=0 at cycle 1;
   - model tx_ready low for cycle 2 only;
   - busy low again at cycle 3+GAP_CYCLES.
2. tk_req with pid=4'h9, addr=7'h15, endp=4'hA; model sender holds tx_ready low 3 cycles:
   - single tx_valid pulse carrying those fields;
   - no second grant until the gap elapses.
3. hs_req and tk_req both held continuously, HS_BURST=2:
   - grant order is hs, hs, tk, hs, hs, tk;
   - each grant separated by the completion wait plus GAP_CYCLES.
4. hs_req with hs_pid=4'h1 (illegal):
   - hs_ack=1 and err_pid=1 at cycle 1;
   - tx_valid stays 0 throughout.
5. Sender model keeps tx_ready=0 after tx_valid:
   - err_timeout pulses exactly TIMEOUT cycles after entering WAIT_DONE;
   - block returns to IDLE after the gap.
6. rst=1 during WAIT_DONE:
   - next cycle all outputs are 0 and busy=0;
   - with tx_ready=1, a fresh request is granted with the normal 1-cycle latency.

Source files
------------

// File: rtl/link_tx_sched_if.sv
// Bundle between the TX scheduler, its two requesters and the link-layer sender.
// The slave modport is the scheduler; the master modport is the surrounding logic.
interface link_tx_sched_if;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       hs_ack;
    logic       tk_req;
    logic [3:0] tk_pid;
    logic [6:0] tk_addr;
    logic [3:0] tk_endp;
    logic       tk_ack;
    logic [3:0] tx_pid;
    logic [6:0] tx_addr;
    logic [3:0] tx_endp;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_pid;
    logic       err_timeout;

    modport master (
        output hs_req, hs_pid, tk_req, tk_pid, tk_addr, tk_endp, tx_ready,
        input  hs_ack, tk_ack, tx_pid, tx_addr, tx_endp, tx_valid, busy,
               err_pid, err_timeout
    );

    modport slave (
        input  hs_req, hs_pid, tk_req, tk_pid, tk_addr, tk_endp, tx_ready,
        output hs_ack, tk_ack, tx_pid, tx_addr, tx_endp, tx_valid, busy,
               err_pid, err_timeout
    );
endinterface

// File: rtl/link_tx_sched.sv
// Link-layer TX scheduler: arbitrates handshake vs token requests, pulses the
// sender once per packet, waits for completion and enforces an inter-packet gap.
module link_tx_sched #(
    parameter int GAP_CYCLES = 4,
    parameter int HS_BURST   = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic           clk,
    input  logic           rst,
    link_tx_sched_if.slave bus
);
    localparam int ST_W  = $clog2(HS_BURST + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [ST_W-1:0]  ST_MAX  = ST_W'(HS_BURST);
    localparam logic [ST_W-1:0]  ST_ONE  = ST_W'(1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    state_t           state_reg, state_next;
    logic [ST_W-1:0]  streak_reg, streak_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic             legal_reg, legal_next;
    logic [3:0]       tx_pid_reg, tx_pid_next;
    logic [6:0]       tx_addr_reg, tx_addr_next;
    logic [3:0]       tx_endp_reg, tx_endp_next;
    logic             hs_ack_reg, hs_ack_next;
    logic             tk_ack_reg, tk_ack_next;
    logic             tx_valid_reg, tx_valid_next;
    logic             busy_reg, busy_next;
    logic             err_pid_reg, err_pid_next;
    logic             err_to_reg, err_to_next;
    logic             pick_hs;
    logic             pid_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            streak_reg   <= '0;
            gap_reg      <= '0;
            wd_reg       <= '0;
            legal_reg    <= 1'b0;
            tx_pid_reg   <= '0;
            tx_addr_reg  <= '0;
            tx_endp_reg  <= '0;
            hs_ack_reg   <= 1'b0;
            tk_ack_reg   <= 1'b0;
            tx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            err_pid_reg  <= 1'b0;
            err_to_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            streak_reg   <= streak_next;
            gap_reg      <= gap_next;
            wd_reg       <= wd_next;
            legal_reg    <= legal_next;
            tx_pid_reg   <= tx_pid_next;
            tx_addr_reg  <= tx_addr_next;
            tx_endp_reg  <= tx_endp_next;
            hs_ack_reg   <= hs_ack_next;
            tk_ack_reg   <= tk_ack_next;
            tx_valid_reg <= tx_valid_next;
            busy_reg     <= busy_next;
            err_pid_reg  <= err_pid_next;
            err_to_reg   <= err_to_next;
        end
    end

    // Registered outputs are computed one edge early so that ack/tx_valid
    // appear during the single ISSUE cycle.
    always_comb begin
        state_next    = state_reg;
        streak_next   = streak_reg;
        gap_next      = gap_reg;
        wd_next       = wd_reg;
        legal_next    = legal_reg;
        tx_pid_next   = tx_pid_reg;
        tx_addr_next  = tx_addr_reg;
        tx_endp_next  = tx_endp_reg;
        hs_ack_next   = 1'b0;
        tk_ack_next   = 1'b0;
        tx_valid_next = 1'b0;
        err_pid_next  = 1'b0;
        err_to_next   = 1'b0;
        pick_hs       = 1'b0;
        pid_ok        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.tx_ready && (bus.hs_req || bus.tk_req)) begin
                    pick_hs = bus.hs_req && (!bus.tk_req || (streak_reg < ST_MAX));
                    if (pick_hs) begin
                        pid_ok       = (bus.hs_pid[1:0] == 2'b10);
                        tx_pid_next  = bus.hs_pid;
                        tx_addr_next = '0;
                        tx_endp_next = '0;
                        if (!bus.tk_req)
                            streak_next = '0;
                        else if (streak_reg != ST_MAX)
                            streak_next = streak_reg + ST_ONE;
                    end else begin
                        pid_ok       = (bus.tk_pid[1:0] == 2'b01);
                        tx_pid_next  = bus.tk_pid;
                        tx_addr_next = bus.tk_addr;
                        tx_endp_next = bus.tk_endp;
                        streak_next  = '0;
                    end
                    hs_ack_next   = pick_hs;
                    tk_ack_next   = !pick_hs;
                    tx_valid_next = pid_ok;
                    err_pid_next  = !pid_ok;
                    legal_next    = pid_ok;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                wd_next = '0;
                if (legal_reg) begin
                    state_next = WAIT_DONE;
                end else begin
                    gap_next   = '0;
                    state_next = GAP;
                end
            end
            WAIT_DONE: begin
                // The completion cycle itself already counts as the first idle
                // cycle of the gap, hence the preload of 1.
                if (bus.tx_ready) begin
                    if (GAP_CYCLES <= 1) begin
                        state_next = IDLE;
                    end else begin
                        gap_next   = GAP_ONE;
                        state_next = GAP;
                    end
                end else begin
                    wd_next = wd_reg + WD_ONE;
                    if ((wd_reg + WD_ONE) == WD_MAX) begin
                        err_to_next = 1'b1;
                        gap_next    = '0;
                        state_next  = GAP;
                    end
                end
            end
            GAP: begin
                if ((gap_reg + GAP_ONE) >= GAP_MAX) begin
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + GAP_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.hs_ack      = hs_ack_reg;
    assign bus.tk_ack      = tk_ack_reg;
    assign bus.tx_pid      = tx_pid_reg;
    assign bus.tx_addr     = tx_addr_reg;
    assign bus.tx_endp     = tx_endp_reg;
    assign bus.tx_valid    = tx_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.err_pid     = err_pid_reg;
    assign bus.err_timeout = err_to_reg;
endmodule

// File: tb/tb_link_tx_sched.sv
// Directed bench for link_tx_sched: scoreboard of expected grants checked on
// every ack, plus timing checks on gap, timeout and reset recovery.
module tb_link_tx_sched;
    localparam int GAP_CYCLES = 4;
    localparam int HS_BURST   = 2;
    localparam int TIMEOUT    = 64;

    typedef struct {
        logic       is_hs;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic       legal;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    link_tx_sched_if bus ();

    link_tx_sched #(
        .GAP_CYCLES(GAP_CYCLES),
        .HS_BURST  (HS_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   ack_cyc[$];
    int   cyc = 0;
    int   vcount = 0;
    int   checks = 0;
    int   failures = 0;
    int   sender_hold = 1;
    logic sender_release = 1'b0;
    int   low_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_hs, input logic [3:0] pid,
                        input logic [6:0] addr, input logic [3:0] endp);
        exp_t e;
        e.is_hs = is_hs;
        e.pid   = pid;
        e.addr  = is_hs ? 7'd0 : addr;
        e.endp  = is_hs ? 4'd0 : endp;
        e.legal = is_hs ? (pid[1:0] == 2'b10) : (pid[1:0] == 2'b01);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            next_cycle();
            n++;
        end
    endtask

    always @(posedge clk) cyc++;

    // Sender model: drops tx_ready for sender_hold cycles after each tx_valid.
    always @(posedge clk) begin
        if (rst || sender_release)
            low_left = 0;
        else if (bus.tx_valid === 1'b1)
            low_left = sender_hold;
        else if (low_left > 0)
            low_left--;
        #1 bus.tx_ready = (low_left == 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.tx_valid === 1'b1) vcount++;
        if (bus.hs_ack === 1'b1 || bus.tk_ack === 1'b1) begin
            $display("cyc=%0d grant hs=%0b tk=%0b pid=%h addr=%h endp=%h valid=%0b err_pid=%0b",
                     cyc, bus.hs_ack, bus.tk_ack, bus.tx_pid, bus.tx_addr, bus.tx_endp,
                     bus.tx_valid, bus.err_pid);
            ack_cyc.push_back(cyc);
            check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_hs_ack", bus.hs_ack, e.is_hs);
                check("sb_tk_ack", bus.tk_ack, !e.is_hs);
                check("sb_pid", bus.tx_pid, e.pid);
                check("sb_addr", bus.tx_addr, e.addr);
                check("sb_endp", bus.tx_endp, e.endp);
                check("sb_valid", bus.tx_valid, e.legal);
                check("sb_err_pid", bus.err_pid, !e.legal);
            end
        end
    end

    initial begin
        int t0, v0, a0, n;

        rst = 1'b1;
        bus.hs_req = 1'b0; bus.hs_pid = '0;
        bus.tk_req = 1'b0; bus.tk_pid = '0; bus.tk_addr = '0; bus.tk_endp = '0;
        repeat (3) next_cycle();
        check("rst_busy", bus.busy, 0);
        check("rst_acks", {bus.hs_ack, bus.tk_ack}, 0);
        check("rst_valid", bus.tx_valid, 0);
        check("rst_fields", {bus.tx_pid, bus.tx_addr, bus.tx_endp}, 0);
        check("rst_errs", {bus.err_pid, bus.err_timeout}, 0);
        rst = 1'b0;
        next_cycle();

        // Single legal handshake, sender busy for one cycle
        sender_hold = 1;
        t0 = cyc;
        push(1'b1, 4'h2, 7'h0, 4'h0);
        bus.hs_req = 1'b1; bus.hs_pid = 4'h2;
        next_cycle();
        check("t1_valid", bus.tx_valid, 1);
        check("t1_ack", bus.hs_ack, 1);
        check("t1_pid", bus.tx_pid, 4'h2);
        check("t1_addr", bus.tx_addr, 0);
        next_cycle();
        bus.hs_req = 1'b0;
        wait_idle(40);
        check("t1_idle_cyc", cyc - t0, 3 + GAP_CYCLES);

        // Token held across two grants; second grant only after completion + gap
        sender_hold = 3;
        t0 = cyc; v0 = vcount; a0 = ack_cyc.size();
        push(1'b0, 4'h9, 7'h15, 4'hA);
        push(1'b0, 4'h9, 7'h15, 4'hA);
        bus.tk_req = 1'b1; bus.tk_pid = 4'h9; bus.tk_addr = 7'h15; bus.tk_endp = 4'hA;
        next_cycle();
        check("t2_valid", bus.tx_valid, 1);
        check("t2_fields", {bus.tx_pid, bus.tx_addr, bus.tx_endp}, {4'h9, 7'h15, 4'hA});
        n = 0;
        while (ack_cyc.size() < a0 + 2 && n < 60) begin next_cycle(); n++; end
        bus.tk_req = 1'b0;
        check("t2_acks", ack_cyc.size() - a0, 2);
        check("t2_pulses", vcount - v0, 2);
        if (ack_cyc.size() >= a0 + 2) begin
            check("t2_first_lat", ack_cyc[a0] - t0, 1);
            check("t2_spacing", ack_cyc[a0+1] - ack_cyc[a0], sender_hold + GAP_CYCLES + 2);
        end
        wait_idle(60);

        // Both requesters held: burst limit interleaves tokens
        sender_hold = 2;
        a0 = ack_cyc.size();
        push(1'b1, 4'hA, 7'h0, 4'h0);
        push(1'b1, 4'hA, 7'h0, 4'h0);
        push(1'b0, 4'h1, 7'h33, 4'h3);
        push(1'b1, 4'hA, 7'h0, 4'h0);
        push(1'b1, 4'hA, 7'h0, 4'h0);
        push(1'b0, 4'h1, 7'h33, 4'h3);
        bus.hs_req = 1'b1; bus.hs_pid = 4'hA;
        bus.tk_req = 1'b1; bus.tk_pid = 4'h1; bus.tk_addr = 7'h33; bus.tk_endp = 4'h3;
        n = 0;
        while (ack_cyc.size() < a0 + 6 && n < 200) begin next_cycle(); n++; end
        bus.hs_req = 1'b0; bus.tk_req = 1'b0;
        check("t3_acks", ack_cyc.size() - a0, 6);
        if (ack_cyc.size() >= a0 + 6) begin
            for (int i = 1; i < 6; i++)
                check("t3_spacing", ack_cyc[a0+i] - ack_cyc[a0+i-1], sender_hold + GAP_CYCLES + 2);
        end
        wait_idle(60);

        // Illegal handshake PID: acked, flagged, never sent
        t0 = cyc; v0 = vcount;
        push(1'b1, 4'h1, 7'h0, 4'h0);
        bus.hs_req = 1'b1; bus.hs_pid = 4'h1;
        next_cycle();
        check("t4_ack", bus.hs_ack, 1);
        check("t4_err_pid", bus.err_pid, 1);
        check("t4_valid", bus.tx_valid, 0);
        next_cycle();
        bus.hs_req = 1'b0;
        check("t4_err_pulse", bus.err_pid, 0);
        wait_idle(40);
        check("t4_no_valid", vcount - v0, 0);
        check("t4_idle_cyc", cyc - t0, 2 + GAP_CYCLES);

        // Sender never completes: watchdog abort
        sender_hold = 1000;
        t0 = cyc;
        push(1'b0, 4'h9, 7'h01, 4'h1);
        bus.tk_req = 1'b1; bus.tk_pid = 4'h9; bus.tk_addr = 7'h01; bus.tk_endp = 4'h1;
        next_cycle();
        check("t5_ack", bus.tk_ack, 1);
        next_cycle();
        bus.tk_req = 1'b0;
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < TIMEOUT + 20) begin next_cycle(); n++; end
        check("t5_timeout_cyc", cyc - t0, 2 + TIMEOUT);
        next_cycle();
        check("t5_timeout_pulse", bus.err_timeout, 0);
        wait_idle(40);
        check("t5_idle_cyc", cyc - t0, 2 + TIMEOUT + GAP_CYCLES);
        sender_release = 1'b1;
        next_cycle();
        sender_release = 1'b0;

        // Reset while waiting for the sender, then normal recovery
        push(1'b1, 4'h2, 7'h0, 4'h0);
        bus.hs_req = 1'b1; bus.hs_pid = 4'h2;
        next_cycle();
        next_cycle();
        bus.hs_req = 1'b0;
        next_cycle();
        check("t6_in_wait", bus.busy, 1);
        rst = 1'b1;
        next_cycle();
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_outs", {bus.hs_ack, bus.tk_ack, bus.tx_valid, bus.err_pid, bus.err_timeout}, 0);
        check("t6_rst_fields", {bus.tx_pid, bus.tx_addr, bus.tx_endp}, 0);
        rst = 1'b0;
        sender_hold = 1;
        push(1'b0, 4'hD, 7'h7F, 4'hF);
        bus.tk_req = 1'b1; bus.tk_pid = 4'hD; bus.tk_addr = 7'h7F; bus.tk_endp = 4'hF;
        next_cycle();
        check("t6_ack", bus.tk_ack, 1);
        check("t6_valid", bus.tx_valid, 1);
        next_cycle();
        bus.tk_req = 1'b0;
        wait_idle(40);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
